// File: rtl/core_ex_stage.sv
// Execute-stage sequencer: drives the external combinational ALU from ID
// inputs, captures its result into a one-entry EX/MEM register, and resolves
// BEQ/BNE branches into a single-cycle redirect pulse.

package core_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } config_t;

    localparam config_t DEFAULT_CONF = '{XLEN: 32};

    typedef enum logic [2:0] {
        ALU_OP_ADD  = 3'd0,
        ALU_OP_AND  = 3'd1,
        ALU_OP_OR   = 3'd2,
        ALU_OP_SRL  = 3'd3,
        ALU_OP_SLTU = 3'd4,
        ALU_OP_SUB  = 3'd5
    } alu_op_t;
endpackage

module core_ex_stage
    import core_pkg::*;
#(
    parameter config_t CONF = DEFAULT_CONF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  alu_op_t                   id_alu_op,
    input  logic [int'(CONF.XLEN)-1:0] id_rs1,
    input  logic [int'(CONF.XLEN)-1:0] id_rs2,
    input  logic [int'(CONF.XLEN)-1:0] id_imm,
    input  logic [int'(CONF.XLEN)-1:0] id_pc,
    input  logic                      id_use_imm,
    input  logic [1:0]                id_branch,
    input  logic [4:0]                id_rd,
    input  logic                      id_reg_write,
    output logic [int'(CONF.XLEN)-1:0] alu_src_a,
    output logic [int'(CONF.XLEN)-1:0] alu_src_b,
    output alu_op_t                   alu_op,
    input  logic [int'(CONF.XLEN)-1:0] alu_res,
    input  logic                      alu_zero,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [int'(CONF.XLEN)-1:0] ex_result,
    output logic [4:0]                ex_rd,
    output logic                      ex_reg_write,
    output logic                      br_taken,
    output logic [int'(CONF.XLEN)-1:0] br_target,
    output logic [31:0]               ex_retired
);
    localparam int XLEN = int'(CONF.XLEN);

    logic is_beq, is_bne, is_branch, accept, consume;

    // 2'b11 is reserved and falls through as a plain ALU op
    assign is_beq    = (id_branch == 2'b01);
    assign is_bne    = (id_branch == 2'b10);
    assign is_branch = is_beq || is_bne;

    assign id_ready = !flush && (!ex_valid || ex_ready);
    assign accept   = id_valid && id_ready;
    assign consume  = ex_valid && ex_ready && !flush;

    // ALU operand select; branches compare rs1 against rs2 via subtraction
    always_comb begin
        alu_src_a = id_rs1;
        alu_src_b = id_use_imm ? id_imm : id_rs2;
        alu_op    = id_alu_op;
        if (is_branch) begin
            alu_src_b = id_rs2;
            alu_op    = ALU_OP_SUB;
        end
    end

    // EX/MEM entry and branch redirect; flush beats accept, accept beats hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_result    <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            br_taken     <= 1'b0;
            br_target    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            br_taken <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_result    <= alu_res;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write && !is_branch;
            br_taken     <= (is_beq && alu_zero) || (is_bne && !alu_zero);
            if (is_branch)
                br_target <= id_pc + id_imm;
        end else begin
            br_taken <= 1'b0;
            if (ex_ready)
                ex_valid <= 1'b0;
        end
    end

    // Count of entries handed to MEM; wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_retired <= '0;
        else if (consume)
            ex_retired <= ex_retired + 32'd1;
    end
endmodule

// File: tb/tb_core_ex_stage.sv
// Scoreboard bench for core_ex_stage: a behavioural model of the EX/MEM
// entry (queue) and branch outcome is updated each cycle; a monitor on the
// falling edge compares DUT outputs against it.

module tb_core_ex_stage;
    import core_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            id_valid = 1'b0;
    logic            id_ready;
    alu_op_t         id_alu_op = ALU_OP_ADD;
    logic [XLEN-1:0] id_rs1 = '0, id_rs2 = '0, id_imm = '0, id_pc = '0;
    logic            id_use_imm = 1'b0;
    logic [1:0]      id_branch = 2'b00;
    logic [4:0]      id_rd = '0;
    logic            id_reg_write = 1'b0;
    logic [XLEN-1:0] alu_src_a, alu_src_b, alu_res;
    alu_op_t         alu_op;
    logic            alu_zero;
    logic            ex_valid;
    logic            ex_ready = 1'b0;
    logic [XLEN-1:0] ex_result;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [31:0]     ex_retired;

    core_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_pc(id_pc),
        .id_use_imm(id_use_imm), .id_branch(id_branch), .id_rd(id_rd),
        .id_reg_write(id_reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .br_taken(br_taken), .br_target(br_target), .ex_retired(ex_retired)
    );

    always #5 clk = ~clk;

    // Reference ALU semantics, used both as the external core_alu stand-in and by the model
    function automatic logic [XLEN-1:0] alu_ref(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_AND:  return a & b;
            ALU_OP_OR:   return a | b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SLTU: return (a < b) ? 1 : 0;
            ALU_OP_SUB:  return a - b;
            default:     return '0;
        endcase
    endfunction

    assign alu_res  = alu_ref(alu_op, alu_src_a, alu_src_b);
    assign alu_zero = (alu_res == '0);

    typedef struct {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            reg_write;
    } entry_t;

    entry_t          exp_q[$];
    logic            exp_br = 1'b0;
    logic [XLEN-1:0] exp_tgt = '0;
    logic [31:0]     exp_ret = '0;
    int              tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs to the model, then advance the model for the coming edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_valid", ex_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("ex_result", ex_result, exp_q[0].result);
                chk("ex_rd", ex_rd, exp_q[0].rd);
                chk("ex_reg_write", ex_reg_write, exp_q[0].reg_write);
            end
            chk("br_taken", br_taken, exp_br);
            if (exp_br) chk("br_target", br_target, exp_tgt);
            chk("ex_retired", ex_retired, exp_ret);
            chk("id_ready", id_ready, !flush && (exp_q.size() == 0 || ex_ready));

            if (flush) begin
                exp_q.delete();
                exp_br = 1'b0;
            end else begin
                logic accept, brn;
                entry_t e;
                accept = id_valid && (exp_q.size() == 0 || ex_ready);
                if (exp_q.size() > 0 && ex_ready) begin
                    void'(exp_q.pop_front());
                    exp_ret++;
                end
                exp_br = 1'b0;
                if (accept) begin
                    brn = (id_branch == 2'b01) || (id_branch == 2'b10);
                    e.result    = brn ? id_rs1 - id_rs2
                                      : alu_ref(id_alu_op, id_rs1, id_use_imm ? id_imm : id_rs2);
                    e.rd        = id_rd;
                    e.reg_write = id_reg_write && !brn;
                    exp_q.push_back(e);
                    if (id_branch == 2'b01) exp_br = (id_rs1 == id_rs2);
                    if (id_branch == 2'b10) exp_br = (id_rs1 != id_rs2);
                    if (brn) exp_tgt = id_pc + id_imm;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t op, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] imm, input logic use_imm, input logic [1:0] br,
                         input logic [XLEN-1:0] pc);
        id_valid = 1'b1; id_alu_op = op; id_rs1 = rs1; id_rs2 = rs2; id_imm = imm;
        id_use_imm = use_imm; id_branch = br; id_pc = pc;
        id_rd = 5'($urandom_range(1, 31)); id_reg_write = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ex_valid"}, ex_valid, 0);
        chk({tag, "_ex_result"}, ex_result, 0);
        chk({tag, "_ex_rd"}, ex_rd, 0);
        chk({tag, "_ex_reg_write"}, ex_reg_write, 0);
        chk({tag, "_br_taken"}, br_taken, 0);
        chk({tag, "_br_target"}, br_target, 0);
        chk({tag, "_ex_retired"}, ex_retired, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // ADD 5+7 with immediate
        ex_ready = 1'b1;
        issue(ALU_OP_ADD, 5, 0, 7, 1'b1, 2'b00, 32'h0);
        cycle();
        chk("t1_valid", ex_valid, 1);
        chk("t1_result", ex_result, 12);
        chk("t1_br", br_taken, 0);

        // back-pressure: entry 12 held while SUB waits
        ex_ready = 1'b0;
        issue(ALU_OP_SUB, 9, 4, 0, 1'b0, 2'b00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_hold_result", ex_result, 12);
            chk("t2_id_ready", id_ready, 0);
        end
        ex_ready = 1'b1;
        cycle();
        chk("t2_sub_result", ex_result, 5);
        chk("t2_retired", ex_retired, 1);
        id_valid = 1'b0;
        cycle();

        // BEQ equal operands, negative offset
        issue(ALU_OP_ADD, 32'h10, 32'h10, 32'hFFFF_FFF8, 1'b1, 2'b01, 32'h100);
        cycle();
        chk("t3_br_taken", br_taken, 1);
        chk("t3_br_target", br_target, 32'hF8);
        chk("t3_reg_write", ex_reg_write, 0);
        id_valid = 1'b0;
        cycle();
        chk("t3_pulse_end", br_taken, 0);

        // BNE not taken, then taken
        issue(ALU_OP_ADD, 3, 3, 16, 1'b0, 2'b10, 32'h200);
        cycle();
        chk("t4_bne_eq", br_taken, 0);
        issue(ALU_OP_ADD, 3, 4, 16, 1'b0, 2'b10, 32'h200);
        cycle();
        chk("t4_bne_ne", br_taken, 1);
        chk("t4_target", br_target, 32'h210);

        // flush with entry stalled and ID presenting
        ex_ready = 1'b0;
        issue(ALU_OP_OR, 1, 2, 0, 1'b0, 2'b00, 32'h0);
        flush = 1'b1;
        cycle();
        chk("t5_flush_valid", ex_valid, 0);
        flush = 1'b0;
        id_valid = 1'b0;
        cycle();
        chk("t5_not_taken", ex_valid, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : XLEN'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
            issue(alu_op_t'($urandom_range(0, 5)), a, b, XLEN'($urandom), 1'($urandom),
                  2'($urandom), XLEN'($urandom));
            id_reg_write = 1'($urandom);
            id_valid     = ($urandom_range(0, 3) != 0);
            ex_ready     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        // async reset between edges while traffic is live
        ex_ready = 1'b0;
        id_valid = 1'b1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        exp_br = 1'b0;
        exp_ret = '0;
        id_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
